// File: rtl/key_sw_io_device_pkg.sv
// Shared constants for the KEY/SW input responder: register addresses,
// CTRL bit positions, idle input levels and the address-decode select type.
package io_pkg;

    localparam logic [31:0] KDATA_ADDR = 32'hF000_0010;
    localparam logic [31:0] SDATA_ADDR = 32'hF000_0014;
    localparam logic [31:0] KCTRL_ADDR = 32'hF000_0110;
    localparam logic [31:0] SCTRL_ADDR = 32'hF000_0114;

    localparam int unsigned READY_BIT   = 0;
    localparam int unsigned OVERRUN_BIT = 2;
    localparam int unsigned IE_BIT      = 8;

    localparam logic [3:0] KEY_IDLE = 4'hF;
    localparam logic [9:0] SW_IDLE  = '0;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_KDATA,
        SEL_SDATA,
        SEL_KCTRL,
        SEL_SCTRL
    } regSel_t;

endpackage

// File: rtl/key_sw_io_device_debouncer.sv
// Two-flop synchronizer plus counter debouncer for one input group;
// 'changed' is high during the cycle whose closing edge updates 'stable'.
module io_debouncer #(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      DEBOUNCE_CYCLES = 10000,
    parameter int unsigned      DEB_WIDTH       = 16,
    parameter logic [WIDTH-1:0] IDLE            = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable,
    output logic             changed
);

    localparam logic [DEB_WIDTH-1:0] LAST = DEB_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]     sync1;
    logic [WIDTH-1:0]     sync2;
    logic [DEB_WIDTH-1:0] count;
    logic                 mismatch;

    assign mismatch = (sync2 != stable);
    assign changed  = mismatch && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= IDLE;
            sync2  <= IDLE;
            stable <= IDLE;
            count  <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (!mismatch) begin
                count <= '0;
            end else if (changed) begin
                stable <= sync2;
                count  <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_sw_io_device.sv
// Memory-mapped read-side I/O: debounced KEY/SW data registers and sticky
// KCTRL/SCTRL status. Define IO_DEVICE_INTR_EN to enable IE bits and intr.
module key_sw_io_device
    import io_pkg::*;
#(
    parameter int unsigned      DBITS           = 32,
    parameter logic [DBITS-1:0] ADDR_KEY        = KDATA_ADDR,
    parameter logic [DBITS-1:0] ADDR_SW         = SDATA_ADDR,
    parameter logic [DBITS-1:0] ADDR_KCTRL      = KCTRL_ADDR,
    parameter logic [DBITS-1:0] ADDR_SCTRL      = SCTRL_ADDR,
    parameter int unsigned      DEBOUNCE_CYCLES = 10000,
    parameter int unsigned      DEB_WIDTH       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] addr,
    input  logic             rdEn,
    input  logic             wrtEn,
    input  logic [DBITS-1:0] wrtData,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic [DBITS-1:0] rdData,
    output logic             hit,
    output logic             intr
);

`ifdef IO_DEVICE_INTR_EN
    localparam bit INTR_EN = 1'b1;
`else
    localparam bit INTR_EN = 1'b0;
`endif

    logic [3:0] keyStable;
    logic [9:0] swStable;
    logic       keyChanged;
    logic       swChanged;
    regSel_t    sel;

    logic kReady, kOverrun, kIe;
    logic sReady, sOverrun, sIe;
    logic kRdClr, sRdClr, kWr, sWr;
    logic unusedWrt;

    io_debouncer #(
        .WIDTH(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .DEB_WIDTH(DEB_WIDTH), .IDLE(KEY_IDLE)
    ) keyDeb (
        .clk(clk), .reset(reset), .raw(KEY),
        .stable(keyStable), .changed(keyChanged)
    );

    io_debouncer #(
        .WIDTH(10), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .DEB_WIDTH(DEB_WIDTH), .IDLE(SW_IDLE)
    ) swDeb (
        .clk(clk), .reset(reset), .raw(SW),
        .stable(swStable), .changed(swChanged)
    );

    always_comb begin
        sel = SEL_NONE;
        if (addr == ADDR_KEY)        sel = SEL_KDATA;
        else if (addr == ADDR_SW)    sel = SEL_SDATA;
        else if (addr == ADDR_KCTRL) sel = SEL_KCTRL;
        else if (addr == ADDR_SCTRL) sel = SEL_SCTRL;
    end

    assign hit    = (sel != SEL_NONE);
    assign kRdClr = rdEn && (sel == SEL_KDATA);
    assign sRdClr = rdEn && (sel == SEL_SDATA);
    assign kWr    = wrtEn && (sel == SEL_KCTRL);
    assign sWr    = wrtEn && (sel == SEL_SCTRL);

    // Keys are active-low on the board; invert so a pressed key reads 1.
    always_comb begin
        rdData = '0;
        if (rdEn) begin
            unique case (sel)
                SEL_KDATA: rdData[3:0] = ~keyStable;
                SEL_SDATA: rdData[9:0] = swStable;
                SEL_KCTRL: begin
                    rdData[READY_BIT]   = kReady;
                    rdData[OVERRUN_BIT] = kOverrun;
                    rdData[IE_BIT]      = kIe;
                end
                SEL_SCTRL: begin
                    rdData[READY_BIT]   = sReady;
                    rdData[OVERRUN_BIT] = sOverrun;
                    rdData[IE_BIT]      = sIe;
                end
                default: rdData = '0;
            endcase
        end
    end

    // A new update wins over a same-edge data read: READY stays set and
    // OVERRUN is only raised when no clearing read accompanies the update.
    always_ff @(posedge clk) begin
        if (reset) begin
            kReady   <= 1'b0;
            kOverrun <= 1'b0;
            kIe      <= 1'b0;
        end else begin
            if (kWr) begin
                if (!wrtData[OVERRUN_BIT]) kOverrun <= 1'b0;
                kIe <= INTR_EN & wrtData[IE_BIT];
            end
            if (keyChanged) begin
                kReady <= 1'b1;
                if (kReady && !kRdClr) kOverrun <= 1'b1;
            end else if (kRdClr) begin
                kReady <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sReady   <= 1'b0;
            sOverrun <= 1'b0;
            sIe      <= 1'b0;
        end else begin
            if (sWr) begin
                if (!wrtData[OVERRUN_BIT]) sOverrun <= 1'b0;
                sIe <= INTR_EN & wrtData[IE_BIT];
            end
            if (swChanged) begin
                sReady <= 1'b1;
                if (sReady && !sRdClr) sOverrun <= 1'b1;
            end else if (sRdClr) begin
                sReady <= 1'b0;
            end
        end
    end

`ifdef IO_DEVICE_INTR_EN
    always_ff @(posedge clk) begin
        if (reset) intr <= 1'b0;
        else       intr <= (kReady & kIe) | (sReady & sIe);
    end
`else
    assign intr = 1'b0;
`endif

    assign unusedWrt = ^{wrtData[DBITS-1:IE_BIT], wrtData[IE_BIT-1:OVERRUN_BIT+1],
                         wrtData[OVERRUN_BIT-1:0]};

endmodule

// File: tb/tb_key_sw_io_device.sv
// Scoreboard bench for key_sw_io_device with DEBOUNCE_CYCLES=4: each read
// pushes its expected rdData/hit/intr; a negedge monitor pops and compares.
module tb_key_sw_io_device;

    localparam logic [31:0] A_KEY   = 32'hF000_0010;
    localparam logic [31:0] A_SW    = 32'hF000_0014;
    localparam logic [31:0] A_KCTRL = 32'hF000_0110;
    localparam logic [31:0] A_SCTRL = 32'hF000_0114;

`ifdef IO_DEVICE_INTR_EN
    localparam bit INTR = 1'b1;
`else
    localparam bit INTR = 1'b0;
`endif
    localparam logic [31:0] IEV = INTR ? 32'h100 : 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        rdEn;
    logic        wrtEn;
    logic [31:0] wrtData;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic [31:0] rdData;
    logic        hit;
    logic        intr;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        hit;
        logic        intr;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    key_sw_io_device #(
        .DBITS(32),
        .DEBOUNCE_CYCLES(4),
        .DEB_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset), .addr(addr), .rdEn(rdEn), .wrtEn(wrtEn),
        .wrtData(wrtData), .KEY(KEY), .SW(SW), .rdData(rdData), .hit(hit),
        .intr(intr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rdEn) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected-read: rdData=%h hit=%b intr=%b, no expectation queued",
                         rdData, hit, intr);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (rdData !== e.data || hit !== e.hit || intr !== e.intr) begin
                    miscompares++;
                    $display("FAIL %s: got rdData=%h hit=%b intr=%b, expected rdData=%h hit=%b intr=%b",
                             e.name, rdData, hit, intr, e.data, e.hit, e.intr);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic h,
                      input logic i, input string n);
        q.push_back('{name: n, data: d, hit: h, intr: i});
        addr = a;
        rdEn = 1'b1;
        tick();
        rdEn = 1'b0;
        addr = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr    = a;
        wrtData = d;
        wrtEn   = 1'b1;
        tick();
        wrtEn   = 1'b0;
        addr    = '0;
    endtask

    task automatic rdwr(input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] d, input string n);
        q.push_back('{name: n, data: d, hit: 1'b1, intr: 1'b0});
        addr    = a;
        wrtData = wd;
        wrtEn   = 1'b1;
        rdEn    = 1'b1;
        tick();
        wrtEn   = 1'b0;
        rdEn    = 1'b0;
        addr    = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; addr = '0; rdEn = 1'b0; wrtEn = 1'b0; wrtData = '0;
        KEY = 4'hF; SW = '0;
        tick(3);
        reset = 1'b0;
        tick(2);

        rd(A_KEY,   32'h0, 1'b1, 1'b0, "reset-kdata");
        rd(A_SW,    32'h0, 1'b1, 1'b0, "reset-sdata");
        rd(A_KCTRL, 32'h0, 1'b1, 1'b0, "reset-kctrl");
        rd(A_SCTRL, 32'h0, 1'b1, 1'b0, "reset-sctrl");
        rd(32'h0000_0000, 32'h0, 1'b0, 1'b0, "unmapped-miss");

        // Update lands on the 6th edge after the change.
        KEY = 4'b1110;
        tick(5);
        rd(A_KCTRL, 32'h0, 1'b1, 1'b0, "key-not-yet-ready");
        rd(A_KCTRL, 32'h1, 1'b1, 1'b0, "key-ready");
        rd(A_KEY,   32'h1, 1'b1, 1'b0, "key0-pressed");
        rd(A_KCTRL, 32'h0, 1'b1, 1'b0, "key-ready-cleared");

        SW = 10'h008;
        tick(3);
        SW = 10'h000;
        tick(8);
        rd(A_SW,    32'h0, 1'b1, 1'b0, "sw-glitch-data");
        rd(A_SCTRL, 32'h0, 1'b1, 1'b0, "sw-glitch-ctrl");
        SW = 10'h008;
        tick(10);
        rd(A_SW,    32'h8, 1'b1, 1'b0, "sw3-held");
        rd(A_SCTRL, 32'h0, 1'b1, 1'b0, "sw-ready-cleared");

        KEY = 4'b1100;
        tick(8);
        KEY = 4'b1000;
        tick(8);
        rd(A_KCTRL, 32'h5, 1'b1, 1'b0, "key-overrun");
        wr(A_KCTRL, 32'h0);
        rd(A_KCTRL, 32'h1, 1'b1, 1'b0, "overrun-cleared");
        wr(A_KCTRL, 32'h4);
        rd(A_KCTRL, 32'h1, 1'b1, 1'b0, "write4-keeps-ready");
        rd(A_KEY,   32'h7, 1'b1, 1'b0, "keys-0-2");
        rd(A_KCTRL, 32'h0, 1'b1, 1'b0, "ready-cleared-2");

        // Clearing read on the very edge the update lands.
        KEY = 4'b0000;
        tick(5);
        rd(A_KEY,   32'h7, 1'b1, 1'b0, "same-edge-old-data");
        rd(A_KCTRL, 32'h1, 1'b1, 1'b0, "same-edge-ready-wins");
        rd(A_KEY,   32'hF, 1'b1, 1'b0, "all-keys");
        wr(A_KEY, 32'hFFFF_FFFF);
        rd(A_KCTRL, 32'h0, 1'b1, 1'b0, "data-write-no-ctrl");
        rd(A_KEY,   32'hF, 1'b1, 1'b0, "data-write-ignored");
        rdwr(A_KCTRL, 32'h104, 32'h0, "rdwr-pre-edge");
        rd(A_KCTRL, IEV, 1'b1, 1'b0, "rdwr-write-took");
        wr(A_KCTRL, 32'h0);

        wr(A_SCTRL, 32'h100);
        SW = 10'h009;
        tick(5);
        rd(A_SCTRL, IEV,           1'b1, 1'b0, "sw0-before-ready");
        rd(A_SCTRL, IEV | 32'h1,   1'b1, 1'b0, "sw0-ready-intr-lag");
        rd(A_SCTRL, IEV | 32'h1,   1'b1, INTR, "sw0-intr");
        rd(A_SW,    32'h9,         1'b1, INTR, "sw-data-9");
        rd(A_SCTRL, IEV,           1'b1, INTR, "intr-drop-lag");
        rd(A_SCTRL, IEV,           1'b1, 1'b0, "intr-dropped");

        // Reset mid-debounce discards the count; change restarts afterwards.
        KEY = 4'b1011;
        tick(3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick(5);
        rd(A_KEY,   32'h0, 1'b1, 1'b0, "post-reset-kdata");
        rd(A_KCTRL, 32'h1, 1'b1, 1'b0, "post-reset-kready");
        rd(A_KEY,   32'h4, 1'b1, 1'b0, "post-reset-key2");
        rd(A_SCTRL, 32'h1, 1'b1, 1'b0, "post-reset-sready");
        rd(A_SW,    32'h9, 1'b1, 1'b0, "post-reset-sdata");

        tick(2);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover-expectations: got %0d pending, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
